// File: rtl/mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_nto1
// Purpose  : N-to-1 valid/ready stream merge with a registered output and a
//            round-robin or fixed-priority arbiter chosen by the mode pin.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_nto1 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [(2**SEL_W)*WIDTH-1:0]   in_data,
    input  logic [(2**SEL_W)-1:0]         in_valid,
    output logic [(2**SEL_W)-1:0]         in_ready,
    input  logic                          mode,
    output logic [WIDTH-1:0]              out_data,
    output logic [SEL_W-1:0]              out_sel,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int c_N = 2**SEL_W;

    logic [WIDTH-1:0] w_ch_data [c_N];

    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [c_N-1:0]   w_gnt;
    logic             w_any_valid;
    logic             w_load_ok;
    logic             w_in_xfer;

    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic [SEL_W-1:0] r_out_sel_q,   w_out_sel_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [SEL_W-1:0] r_rr_ptr_q,    w_rr_ptr_d;

    generate
        for (genvar gi = 0; gi < c_N; gi++) begin : g_unpack
            assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_load_ok   = !r_out_valid_q || out_ready;
    assign w_any_valid = |in_valid;
    assign w_in_xfer   = w_any_valid && w_load_ok;

    // Scan offsets from farthest to nearest so the nearest valid candidate wins.
    // Fixed priority scans from index 0, round-robin from the pointer with wrap.
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        for (int off = c_N - 1; off >= 0; off--) begin
            w_cand = mode ? SEL_W'(off) : r_rr_ptr_q + SEL_W'(off);
            if (in_valid[w_cand]) begin
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt            = '0;
        w_gnt[w_gnt_idx] = 1'b1;
        in_ready         = (rst_n && w_any_valid && w_load_ok) ? w_gnt : '0;
    end

    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_sel_d   = r_out_sel_q;
        w_out_valid_d = r_out_valid_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        if (w_in_xfer) begin
            w_out_data_d  = w_ch_data[w_gnt_idx];
            w_out_sel_d   = w_gnt_idx;
            w_out_valid_d = 1'b1;
            if (!mode) begin
                w_rr_ptr_d = w_gnt_idx + SEL_W'(1);
            end
        end else if (r_out_valid_q && out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data_q  <= '0;
            r_out_sel_q   <= '0;
            r_out_valid_q <= 1'b0;
            r_rr_ptr_q    <= '0;
        end else begin
            r_out_data_q  <= w_out_data_d;
            r_out_sel_q   <= w_out_sel_d;
            r_out_valid_q <= w_out_valid_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_sel   = r_out_sel_q;
    assign out_valid = r_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_nto1
// Purpose  : Directed bench for mux_rr_nto1; expected words go into a queue
//            that a monitor drains at every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_nto1;

    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int c_N   = 4;

    logic                   clk;
    logic                   rst_n;
    logic [c_N*WIDTH-1:0]   in_data;
    logic [c_N-1:0]         in_valid;
    logic [c_N-1:0]         in_ready;
    logic                   mode;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_valid;
    logic                   out_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [SEL_W+WIDTH-1:0] sb[$];

    mux_rr_nto1 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic expect_word(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data);
        sb.push_back({sel, data});
    endtask

    // Apply one cycle of inputs; returns at the following posedge + 1.
    task automatic cyc(input logic [c_N-1:0] v, input logic r, input logic m);
        in_valid  = v;
        out_ready = r;
        mode      = m;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got sel=%0d data=%0h, expected none", out_sel, out_data);
            end else begin
                chk("out_word", {22'd0, out_sel, out_data}, {22'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);

        // Reset state with every channel requesting
        #2;
        chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_data", {24'd0, out_data}, 32'h0);
        chk("rst_out_sel", {30'd0, out_sel}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", {28'd0, in_ready}, 32'h0);
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'h0);
        rst_n = 1'b1;
        expect_word(2'd0, 8'hC0);
        cyc(4'b1111, 1'b1, 1'b0);                       // ptr -> 1

        // Lone channel 3 wins from ptr=1, ptr wraps to 0
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        expect_word(2'd3, 8'hA3);
        cyc(4'b1000, 1'b1, 1'b0);

        // Round-robin rotation, one word per clock
        expect_word(2'd0, 8'hA0);
        expect_word(2'd1, 8'hA1);
        expect_word(2'd2, 8'hA2);
        expect_word(2'd3, 8'hA3);
        expect_word(2'd0, 8'hA0);
        repeat (5) cyc(4'b1111, 1'b1, 1'b0);           // ptr -> 1

        // Fixed priority: channel 1 beats channel 3 until it drops
        set_data(8'h00, 8'h11, 8'h22, 8'h33);
        in_valid = 4'b1010;
        mode     = 1'b1;
        #1;
        chk("fixed_in_ready", {28'd0, in_ready}, 32'h2);
        expect_word(2'd1, 8'h11);
        expect_word(2'd1, 8'h11);
        expect_word(2'd1, 8'h11);
        repeat (3) cyc(4'b1010, 1'b1, 1'b1);
        expect_word(2'd3, 8'h33);
        cyc(4'b1000, 1'b1, 1'b1);
        cyc(4'b0000, 1'b1, 1'b0);                       // drain, ptr stays 1

        // Backpressure: 0x5A held for 5 cycles, then drains with no bubble
        set_data(8'h5A, 8'h6B, 8'h00, 8'h00);
        expect_word(2'd0, 8'h5A);
        cyc(4'b0001, 1'b0, 1'b0);                       // ptr -> 1
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_data", {24'd0, out_data}, 32'h5A);
            chk("bp_in_ready", {28'd0, in_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'h1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {28'd0, in_ready}, 32'h2);
        expect_word(2'd1, 8'h6B);
        cyc(4'b0011, 1'b1, 1'b0);                       // ptr -> 2
        cyc(4'b0000, 1'b1, 1'b0);

        // Pointer wrap with sparse valid
        set_data(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        expect_word(2'd2, 8'hE2);
        cyc(4'b0100, 1'b1, 1'b0);                       // ptr -> 3
        expect_word(2'd0, 8'hE0);
        cyc(4'b0001, 1'b1, 1'b0);                       // ptr -> 1
        expect_word(2'd1, 8'hE1);
        cyc(4'b1111, 1'b1, 1'b0);                       // ptr -> 2
        cyc(4'b0000, 1'b1, 1'b0);

        // Mid-stream reset discards the held word and clears the pointer
        set_data(8'h77, 8'h81, 8'h82, 8'h83);
        cyc(4'b0001, 1'b0, 1'b0);                       // ptr -> 1
        chk("pre_rst_out_data", {24'd0, out_data}, 32'h77);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'h1);
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("async_rst_out_data", {24'd0, out_data}, 32'h0);
        chk("async_rst_in_ready", {28'd0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_word(2'd0, 8'h77);
        cyc(4'b1111, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
